// File: rtl/crp16_memory_responder_pkg.sv
// crp16_memory_responder_pkg
//   Shared definitions for the CRP16 memory responder.
//   - mem_state_e   : clear-sequencer state encoding (CLEAR=0, READY=1)
//   - MEM_DEAD_WORD : read-back value on both ports while the array is not ready
//   - MEM_NOOP_WORD : CRP16 no-op encoding, the default clear value
package crp16_memory_responder_pkg;

  typedef enum logic {
    MEM_CLEAR = 1'b0,
    MEM_READY = 1'b1
  } mem_state_e;

  localparam logic [15:0] MEM_DEAD_WORD = 16'hdead;
  localparam logic [15:0] MEM_NOOP_WORD = 16'h0000;

endpackage

// File: rtl/crp16_ram_array.sv
// crp16_ram_array
//   Word storage for the CRP16 memory responder.
//   Ports:
//     clock                             : write clock (rising edge)
//     rd_addr_a_i / q_a_o               : combinational read port A
//     rd_addr_b_i / q_b_o               : combinational read port B
//     we_a_i / wr_addr_a_i / wr_data_a_i: write port A (lowest priority)
//     we_b_i / wr_addr_b_i / wr_data_b_i: write port B
//     we_l_i / wr_addr_l_i / wr_data_l_i: load/clear write port (highest priority)
//   Writes to distinct addresses all commit at the same edge.
module crp16_ram_array #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clock,
  input  logic [ADDR_WIDTH-1:0] rd_addr_a_i,
  output logic [15:0]           q_a_o,
  input  logic [ADDR_WIDTH-1:0] rd_addr_b_i,
  output logic [15:0]           q_b_o,
  input  logic                  we_a_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_a_i,
  input  logic [15:0]           wr_data_a_i,
  input  logic                  we_b_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_b_i,
  input  logic [15:0]           wr_data_b_i,
  input  logic                  we_l_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_l_i,
  input  logic [15:0]           wr_data_l_i
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [15:0] mem_q [DEPTH];

  // On a shared address the later assignment wins: load over B over A.
  always_ff @(posedge clock) begin
    if (we_a_i) mem_q[wr_addr_a_i] <= wr_data_a_i;
    if (we_b_i) mem_q[wr_addr_b_i] <= wr_data_b_i;
    if (we_l_i) mem_q[wr_addr_l_i] <= wr_data_l_i;
  end

  assign q_a_o = mem_q[rd_addr_a_i];
  assign q_b_o = mem_q[rd_addr_b_i];

endmodule

// File: rtl/crp16_memory_responder.sv
// crp16_memory_responder
//   Responder end of the CRP16 dual-port RAM interface. After reset a clear
//   sequencer fills every word with CLEAR_WORD; afterwards both CPU ports and
//   the loader are live.
//   Ports:
//     clock, resetn (sync, active low)
//     address_a/data_a/wren_a/q_a : port A (fetch)
//     address_b/data_b/wren_b/q_b : port B (load/store)
//     load_valid/load_ready/load_addr/load_data : program preload handshake
//     mem_ready : array initialised, ports live
//
//   state     | meaning
//   MEM_CLEAR | writing CLEAR_WORD at clr_cnt_q, ports read 16'hdead
//   MEM_READY | normal operation, terminal until reset
module crp16_memory_responder
  import crp16_memory_responder_pkg::*;
#(
  parameter int          ADDR_WIDTH = 8,
  parameter logic [15:0] CLEAR_WORD = MEM_NOOP_WORD
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [15:0] address_a,
  input  logic [15:0] data_a,
  input  logic        wren_a,
  output logic [15:0] q_a,
  input  logic [15:0] address_b,
  input  logic [15:0] data_b,
  input  logic        wren_b,
  output logic [15:0] q_b,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [15:0] load_addr,
  input  logic [15:0] load_data,
  output logic        mem_ready
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  mem_state_e            state_q;
  logic [ADDR_WIDTH-1:0] clr_cnt_q;
  logic [ADDR_WIDTH-1:0] clr_cnt_d;
  logic                  mem_ready_q;

  logic                  clearing;
  logic                  live;
  logic                  we_l;
  logic [ADDR_WIDTH-1:0] wr_addr_l;
  logic [15:0]           wr_data_l;
  logic [15:0]           rd_a;
  logic [15:0]           rd_b;

  assign clr_cnt_d = clr_cnt_q + 1'b1;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q     <= MEM_CLEAR;
      clr_cnt_q   <= '0;
      mem_ready_q <= 1'b0;
    end else begin
      case (state_q)
        MEM_CLEAR: begin
          if (clr_cnt_q == LAST_ADDR) begin
            state_q     <= MEM_READY;
            mem_ready_q <= 1'b1;
          end else begin
            clr_cnt_q <= clr_cnt_d;
          end
        end
        MEM_READY: begin
          state_q     <= MEM_READY;
          mem_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= MEM_CLEAR;
          clr_cnt_q   <= '0;
          mem_ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Reset low suppresses every write, including the clear write itself.
  assign clearing = resetn && (state_q == MEM_CLEAR);
  assign live     = resetn && (state_q == MEM_READY);

  // The clear sequencer borrows the load write port; loads are impossible
  // during CLEAR since load_ready is low, so nothing is lost.
  assign we_l      = clearing | (live & load_valid & mem_ready_q);
  assign wr_addr_l = clearing ? clr_cnt_q  : load_addr[ADDR_WIDTH-1:0];
  assign wr_data_l = clearing ? CLEAR_WORD : load_data;

  crp16_ram_array #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram_array (
    .clock       (clock),
    .rd_addr_a_i (address_a[ADDR_WIDTH-1:0]),
    .q_a_o       (rd_a),
    .rd_addr_b_i (address_b[ADDR_WIDTH-1:0]),
    .q_b_o       (rd_b),
    .we_a_i      (live & wren_a),
    .wr_addr_a_i (address_a[ADDR_WIDTH-1:0]),
    .wr_data_a_i (data_a),
    .we_b_i      (live & wren_b),
    .wr_addr_b_i (address_b[ADDR_WIDTH-1:0]),
    .wr_data_b_i (data_b),
    .we_l_i      (we_l),
    .wr_addr_l_i (wr_addr_l),
    .wr_data_l_i (wr_data_l)
  );

  assign q_a        = mem_ready_q ? rd_a : MEM_DEAD_WORD;
  assign q_b        = mem_ready_q ? rd_b : MEM_DEAD_WORD;
  assign mem_ready  = mem_ready_q;
  assign load_ready = mem_ready_q;

  // Upper address bits are intentionally ignored so addresses wrap.
  if (ADDR_WIDTH < 16) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^{address_a[15:ADDR_WIDTH], address_b[15:ADDR_WIDTH],
                              load_addr[15:ADDR_WIDTH]};
  end

endmodule
